// File: rtl/rv_decode_pkg.sv
// Shared encodings for the RV32 decode stage: opcodes, ALU/MDU op codes, immediate
// formats, operand selects and the decoded control word.
package rv_decode_pkg;

    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcOp     = 7'b0110011;

    localparam logic [6:0] F7Base = 7'b0000000;
    localparam logic [6:0] F7Alt  = 7'b0100000;
    localparam logic [6:0] F7Mul  = 7'b0000001;

    // Base ops are {AluPfxBase, funct3}; SUB/SRA live at 0100x; M ops are {AluPfxMul, funct3}.
    localparam logic [1:0] AluPfxBase = 2'b00;
    localparam logic [1:0] AluPfxMul  = 2'b10;
    localparam logic [4:0] AluAdd     = 5'b00000;
    localparam logic [4:0] AluSub     = 5'b01000;
    localparam logic [4:0] AluSra     = 5'b01001;

    localparam logic [2:0] ImmI      = 3'b000;
    localparam logic [2:0] ImmIShamt = 3'b001;
    localparam logic [2:0] ImmS      = 3'b010;
    localparam logic [2:0] ImmB      = 3'b011;
    localparam logic [2:0] ImmU      = 3'b100;
    localparam logic [2:0] ImmJ      = 3'b101;

    localparam logic [1:0] SrcARs1  = 2'b00;
    localparam logic [1:0] SrcAPc   = 2'b01;
    localparam logic [1:0] SrcAZero = 2'b10;
    localparam logic [1:0] SrcBRs2  = 2'b00;
    localparam logic [1:0] SrcBImm  = 2'b01;
    localparam logic [1:0] SrcBFour = 2'b10;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       mem_read;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic       jalr;
        logic       reg_write;
        logic       wb_mem;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [4:0] alu_op;
        logic [2:0] imm_sel;
        logic       is_muldiv;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/rv_decode_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
// slave = decode stage, master = surrounding pipeline.
interface rv_decode_if;
    import rv_decode_pkg::*;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic        out_mem_read;
    logic        out_mem_write;
    logic        out_jump;
    logic        out_branch;
    logic        out_jalr;
    logic        out_reg_write;
    logic        out_wb_mem;
    logic [1:0]  out_alu_src_a;
    logic [1:0]  out_alu_src_b;
    logic [4:0]  out_alu_op;
    logic [2:0]  out_imm_sel;
    logic        out_is_muldiv;
    logic        out_illegal;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd,
        input  out_mem_read, out_mem_write, out_jump, out_branch, out_jalr,
        input  out_reg_write, out_wb_mem, out_alu_src_a, out_alu_src_b,
        input  out_alu_op, out_imm_sel, out_is_muldiv, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd,
        output out_mem_read, out_mem_write, out_jump, out_branch, out_jalr,
        output out_reg_write, out_wb_mem, out_alu_src_a, out_alu_src_b,
        output out_alu_op, out_imm_sel, out_is_muldiv, out_illegal
    );

endinterface

// File: rtl/rv_instr_fifo.sv
// Synchronous FIFO of {pc, instr} words with flush; push on full and pop on empty
// are ignored, flush empties the queue and drops any concurrent push.
module rv_instr_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wptr_q, rptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign rdata_o = mem_q[rptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/rv_decode_stage.sv
// RV32I(+M) decode stage: instruction FIFO, combinational decode of the FIFO head,
// and a registered control-word output with valid/ready backpressure and flush.
module rv_decode_stage
    import rv_decode_pkg::*;
#(
    parameter int unsigned QDEPTH = 2,
    parameter bit          EN_M   = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    rv_decode_if.slave    bus
);
    logic        fifo_full, fifo_empty, pop;
    logic [31:0] head_pc, head_instr;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd_field;
    logic        legal;
    ctrl_t       dec, out_q;
    logic        out_valid_q;
    logic [31:0] out_pc_q;

    assign pop = !fifo_empty && (!out_valid_q || bus.out_ready);

    rv_instr_fifo #(
        .DEPTH (QDEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .push_i  (bus.in_valid),
        .wdata_i ({bus.in_pc, bus.in_instr}),
        .pop_i   (pop),
        .rdata_o ({head_pc, head_instr}),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign opcode   = head_instr[6:0];
    assign rd_field = head_instr[11:7];
    assign funct3   = head_instr[14:12];
    assign funct7   = head_instr[31:25];

    always_comb begin
        dec           = '0;
        dec.rs1       = head_instr[19:15];
        dec.rs2       = head_instr[24:20];
        dec.alu_src_a = SrcARs1;
        dec.alu_src_b = SrcBRs2;
        dec.alu_op    = AluAdd;
        dec.imm_sel   = ImmI;
        legal         = 1'b1;
        case (opcode)
            OpcOp: begin
                dec.reg_write = 1'b1;
                if (funct7 == F7Base) begin
                    dec.alu_op = {AluPfxBase, funct3};
                end else if (funct7 == F7Alt && (funct3 == 3'b000 || funct3 == 3'b101)) begin
                    dec.alu_op = (funct3 == 3'b000) ? AluSub : AluSra;
                end else if (EN_M && funct7 == F7Mul) begin
                    dec.alu_op    = {AluPfxMul, funct3};
                    dec.is_muldiv = 1'b1;
                end else begin
                    legal = 1'b0;
                end
            end
            OpcOpImm: begin
                dec.reg_write = 1'b1;
                dec.alu_src_b = SrcBImm;
                dec.alu_op    = {AluPfxBase, funct3};
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    dec.imm_sel = ImmIShamt;
                    if (funct7 == F7Alt && funct3 == 3'b101) dec.alu_op = AluSra;
                    else if (funct7 != F7Base)                legal = 1'b0;
                end
            end
            OpcLoad: begin
                dec.mem_read  = 1'b1;
                dec.reg_write = 1'b1;
                dec.wb_mem    = 1'b1;
                dec.alu_src_b = SrcBImm;
                legal = !(funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111);
            end
            OpcStore: begin
                dec.mem_write = 1'b1;
                dec.alu_src_b = SrcBImm;
                dec.imm_sel   = ImmS;
                legal = (funct3 <= 3'b010);
            end
            OpcBranch: begin
                dec.branch  = 1'b1;
                dec.imm_sel = ImmB;
                legal = !(funct3 == 3'b010 || funct3 == 3'b011);
            end
            OpcJal: begin
                dec.jump      = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_src_a = SrcAPc;
                dec.alu_src_b = SrcBFour;
                dec.imm_sel   = ImmJ;
            end
            OpcJalr: begin
                dec.jalr      = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_src_a = SrcAPc;
                dec.alu_src_b = SrcBFour;
                legal = (funct3 == 3'b000);
            end
            OpcLui: begin
                dec.reg_write = 1'b1;
                dec.alu_src_a = SrcAZero;
                dec.alu_src_b = SrcBImm;
                dec.imm_sel   = ImmU;
            end
            OpcAuipc: begin
                dec.reg_write = 1'b1;
                dec.alu_src_a = SrcAPc;
                dec.alu_src_b = SrcBImm;
                dec.imm_sel   = ImmU;
            end
            default: legal = 1'b0;
        endcase

        // Illegal words carry only their source indices and the illegal flag downstream.
        if (!legal) begin
            dec         = '0;
            dec.rs1     = head_instr[19:15];
            dec.rs2     = head_instr[24:20];
            dec.illegal = 1'b1;
        end
        dec.reg_write = dec.reg_write && (rd_field != 5'd0);
        dec.rd        = dec.reg_write ? rd_field : 5'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_q       <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (pop) begin
            out_valid_q <= 1'b1;
            out_pc_q    <= head_pc;
            out_q       <= dec;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready      = !fifo_full;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_pc        = out_pc_q;
    assign bus.out_rs1       = out_q.rs1;
    assign bus.out_rs2       = out_q.rs2;
    assign bus.out_rd        = out_q.rd;
    assign bus.out_mem_read  = out_q.mem_read;
    assign bus.out_mem_write = out_q.mem_write;
    assign bus.out_jump      = out_q.jump;
    assign bus.out_branch    = out_q.branch;
    assign bus.out_jalr      = out_q.jalr;
    assign bus.out_reg_write = out_q.reg_write;
    assign bus.out_wb_mem    = out_q.wb_mem;
    assign bus.out_alu_src_a = out_q.alu_src_a;
    assign bus.out_alu_src_b = out_q.alu_src_b;
    assign bus.out_alu_op    = out_q.alu_op;
    assign bus.out_imm_sel   = out_q.imm_sel;
    assign bus.out_is_muldiv = out_q.is_muldiv;
    assign bus.out_illegal   = out_q.illegal;

endmodule
